// File: rtl/image_line_ctrl.sv
// image_line_ctrl
//   Upstream feeder for a 3x3 convolution stage. Raster pixels are written
//   into four rotating line buffers. Once three complete lines are held, one
//   line of 3x3 windows is read out (one window per cycle, LINE_W windows),
//   after which the oldest buffer is released and o_intr pulses so the host
//   can send another line.
//
// Parameters
//   LINE_W  pixels per line (power of 2, >= 4)
//   DATA_W  bits per pixel
//
// Ports
//   axi_clk             in   clock, rising edge
//   axi_reset           in   asynchronous reset, active-high
//   i_pixel_data        in   DATA_W    pixel to store
//   i_pixel_data_valid  in   1         pixel present this cycle
//   o_pixel_data        out  9*DATA_W  window {top[c..c+2], mid[c..c+2], bot[c..c+2]}, MSB first
//   o_pixel_data_valid  out  1         window valid this cycle
//   o_intr              out  1         one-cycle pulse with the last window of a line
//   o_overflow          out  1         sticky dropped-pixel flag (OVERFLOW_FLAG_EN only)
//
// Configuration
//   OVERFLOW_FLAG_EN  when defined, adds o_overflow. The datapath is the same
//                     either way; without it, pixels arriving while full are
//                     dropped silently.

module image_line_ctrl #(
  parameter int LINE_W = 512,
  parameter int DATA_W = 8
) (
  input  logic                axi_clk,
  input  logic                axi_reset,
  input  logic [DATA_W-1:0]   i_pixel_data,
  input  logic                i_pixel_data_valid,
  output logic [9*DATA_W-1:0] o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_intr
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                o_overflow
`endif
);

  localparam int COL_W = $clog2(LINE_W);
  localparam int CNT_W = $clog2(4 * LINE_W + 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(4 * LINE_W);
  localparam logic [CNT_W-1:0] THREE_ROWS = CNT_W'(3 * LINE_W);

  typedef enum logic {
    IDLE,
    RD_LINE
  } ctrlState_t;

  ctrlState_t state;

  logic [DATA_W-1:0] lineMem [4][LINE_W];

  logic [COL_W-1:0] wrCol;
  logic [COL_W-1:0] rdCol;
  logic [1:0]       wrBuf;
  logic [1:0]       rdBuf;
  logic [CNT_W-1:0] pixCnt;

  logic             rdEn;
  logic             wrEn;
  logic [9*DATA_W-1:0] window;

  // A read slot frees one pixel in the same cycle, so a full store still
  // accepts the incoming pixel whenever a window is being read.
  assign rdEn = (state == RD_LINE);
  assign wrEn = i_pixel_data_valid && ((pixCnt != FULL_CNT) || rdEn);

  // Buffer storage is never reset.
  always_ff @(posedge axi_clk) begin
    if (wrEn) begin
      lineMem[wrBuf][wrCol] <= i_pixel_data;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      wrCol <= '0;
      wrBuf <= '0;
    end else if (wrEn) begin
      if (wrCol == LAST_COL) begin
        wrCol <= '0;
        wrBuf <= wrBuf + 2'd1;
      end else begin
        wrCol <= wrCol + COL_W'(1);
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      pixCnt <= '0;
    end else begin
      case ({wrEn, rdEn})
        2'b10:   pixCnt <= pixCnt + CNT_W'(1);
        2'b01:   pixCnt <= pixCnt - CNT_W'(1);
        default: pixCnt <= pixCnt;
      endcase
    end
  end

  // Row and column indices wrap naturally in their 2-bit / COL_W-bit widths,
  // giving the mod-4 buffer rotation and the mod-LINE_W column wrap at the
  // right edge of the line.
  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        window[(8 - (r * 3 + k)) * DATA_W +: DATA_W] =
          lineMem[rdBuf + 2'(r)][rdCol + COL_W'(k)];
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state              <= IDLE;
      rdCol              <= '0;
      rdBuf              <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
      case (state)
        IDLE: begin
          rdCol <= '0;
          if (pixCnt >= THREE_ROWS) begin
            state <= RD_LINE;
          end
        end
        RD_LINE: begin
          o_pixel_data       <= window;
          o_pixel_data_valid <= 1'b1;
          if (rdCol == LAST_COL) begin
            rdCol  <= '0;
            rdBuf  <= rdBuf + 2'd1;
            o_intr <= 1'b1;
            state  <= IDLE;
          end else begin
            rdCol <= rdCol + COL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      o_overflow <= 1'b0;
    end else if (i_pixel_data_valid && !wrEn) begin
      o_overflow <= 1'b1;
    end
  end
`endif

endmodule
